// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART types and constants: TX state encoding, data_bits codes, minimum bit time.
// BREAK exists only when TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef TX_BREAK_EN
    , BREAK
`endif
  } tx_state_t;

  localparam logic [1:0] DB5 = 2'b00;
  localparam logic [1:0] DB6 = 2'b01;
  localparam logic [1:0] DB7 = 2'b10;
  localparam logic [1:0] DB8 = 2'b11;

  localparam int unsigned MIN_K = 2;

  // Data bits per frame, saturated to the datapath width.
  function automatic int unsigned frame_bits(input logic [1:0] db, input int unsigned max_bits);
    int unsigned n;
    unique case (db)
      DB5:     n = 5;
      DB6:     n = 6;
      DB7:     n = 7;
      DB8:     n = 8;
      default: n = 8;
    endcase
    return (n > max_bits) ? max_bits : n;
  endfunction

  function automatic logic data_parity(input logic [31:0] d, input int unsigned n);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) p ^= d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered occupancy; writes into a full FIFO are dropped
// even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign full    = (r_level == (AW+1)'(DEPTH));
  assign empty   = (r_level == '0);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rptr];
  assign level   = r_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frame format is latched per entry at pop time.
// Optional macro TX_BREAK_EN adds send_break and the BREAK/mark-after-break sequence.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DIV_W  = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [1:0]             data_bits,
  input  logic                   pen,
  input  logic                   ohel,
  input  logic                   stop2,
  input  logic [DIV_W-1:0]       k,
`ifdef TX_BREAK_EN
  input  logic                   send_break,
`endif
  output logic                   tx_rdy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx_busy,
  output logic                   tx
);

  localparam int unsigned BW = $clog2(DATA_W + 1);

  tx_state_t         r_state;
  logic              r_tx;
  logic              r_busy;
  logic              r_overflow;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_keff;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_nbits;
  logic [BW-1:0]     r_bitidx;
  logic              r_pen;
  logic              r_par;
  logic              r_stop2;
  logic              r_stopidx;
`ifdef TX_BREAK_EN
  logic              r_mark;
`endif

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_rd_data;
  logic [DIV_W-1:0]  w_keff;
  logic              w_tick;
  logic              w_frame_end;
  logic              w_brk;
  logic              w_pop;
  logic              w_cnt_hold;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .level   (level),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_keff   = (k < DIV_W'(MIN_K)) ? DIV_W'(MIN_K) : k;
  assign w_tick   = (r_cnt == r_keff - DIV_W'(1));
  assign tx_rdy   = !w_full;
  assign overflow = r_overflow;
  assign tx_busy  = r_busy;
  assign tx       = r_tx;

  always_comb begin
    w_frame_end = (r_state == STOP) && w_tick && (!r_stop2 || r_stopidx);
    w_brk       = 1'b0;
    w_cnt_hold  = (r_state == IDLE);
`ifdef TX_BREAK_EN
    w_brk       = send_break && ((r_state == IDLE) || w_frame_end);
    w_cnt_hold  = w_cnt_hold || ((r_state == BREAK) && !r_mark);
`endif
    w_pop       = !w_empty && !w_brk && ((r_state == IDLE) || w_frame_end);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
      r_keff     <= DIV_W'(MIN_K);
      r_shift    <= '0;
      r_nbits    <= '0;
      r_bitidx   <= '0;
      r_pen      <= 1'b0;
      r_par      <= 1'b0;
      r_stop2    <= 1'b0;
      r_stopidx  <= 1'b0;
`ifdef TX_BREAK_EN
      r_mark     <= 1'b0;
`endif
    end else begin
      r_overflow <= wr_en && w_full;

      // Line level follows the state one clock later, so the start bit begins the edge after the pop.
      unique case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
        PARITY:  r_tx <= r_par;
`ifdef TX_BREAK_EN
        BREAK:   r_tx <= r_mark;
`endif
        default: r_tx <= 1'b1;
      endcase

      if (w_cnt_hold || w_tick) r_cnt <= '0;
      else                      r_cnt <= r_cnt + DIV_W'(1);

      unique case (r_state)
        START: if (w_tick) begin
          r_state  <= DATA;
          r_bitidx <= '0;
        end
        DATA: if (w_tick) begin
          r_shift  <= r_shift >> 1;
          r_bitidx <= r_bitidx + BW'(1);
          if (r_bitidx == r_nbits - BW'(1)) r_state <= r_pen ? PARITY : STOP;
        end
        PARITY: if (w_tick) r_state <= STOP;
        STOP: if (w_tick) begin
          r_stopidx <= 1'b1;
          if (w_frame_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
`ifdef TX_BREAK_EN
        BREAK: begin
          if (!r_mark) begin
            r_mark <= !send_break;
          end else if (w_tick) begin
            r_state <= IDLE;
            r_mark  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase

`ifdef TX_BREAK_EN
      if (w_brk) begin
        r_state <= BREAK;
        r_busy  <= 1'b1;
        r_mark  <= 1'b0;
        r_keff  <= w_keff;
      end
`endif

      if (w_pop) begin
        r_state   <= START;
        r_busy    <= 1'b1;
        r_shift   <= w_rd_data;
        r_nbits   <= BW'(frame_bits(data_bits, DATA_W));
        r_pen     <= pen;
        r_par     <= data_parity(32'(w_rd_data), frame_bits(data_bits, DATA_W)) ^ ohel;
        r_stop2   <= stop2;
        r_stopidx <= 1'b0;
        r_keff    <= w_keff;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, latency, overflow, back-to-back frames, async reset.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [1:0]  data_bits = 2'b11;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;
  logic        stop2 = 1'b0;
  logic [18:0] k = 19'd4;
`ifdef TX_BREAK_EN
  logic        send_break = 1'b0;
`endif
  logic        tx_rdy;
  logic        overflow;
  logic [3:0]  level;
  logic        tx_busy;
  logic        tx;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_fifo #(
    .DATA_W (8),
    .DEPTH  (8),
    .DIV_W  (19)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .data_bits  (data_bits),
    .pen        (pen),
    .ohel       (ohel),
    .stop2      (stop2),
    .k          (k),
`ifdef TX_BREAK_EN
    .send_break (send_break),
`endif
    .tx_rdy     (tx_rdy),
    .overflow   (overflow),
    .level      (level),
    .tx_busy    (tx_busy),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // seq holds the expected line level per bit time, seq[0] sent first.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] db,
                           input logic p, input logic o, input logic s2, input logic [18:0] kv,
                           input int unsigned keff, input logic [15:0] seq, input int unsigned len);
    int unsigned total;
    total = len * keff;
    data_bits = db; pen = p; ohel = o; stop2 = s2; k = kv;
    wr_data = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk({tag, ".lvl_n"},  32'(level),   32'd1);
    chk({tag, ".busy_n"}, 32'(tx_busy), 32'd0);
    chk({tag, ".tx_n"},   32'(tx),      32'd1);
    @(posedge clk); #1;
    chk({tag, ".busy_n1"}, 32'(tx_busy), 32'd1);
    chk({tag, ".lvl_n1"},  32'(level),   32'd0);
    chk({tag, ".tx_n1"},   32'(tx),      32'd1);
    data_bits = ~db; pen = ~p; ohel = ~o; stop2 = ~s2; k = kv + 19'd5;
    for (int unsigned c = 0; c < total; c++) begin
      @(posedge clk); #1;
      chk({tag, ".tx"}, 32'(tx), 32'(seq[c / keff]));
      if (c == total - 2) chk({tag, ".busy_end"}, 32'(tx_busy), 32'd1);
      if (c == total - 1) chk({tag, ".busy_off"}, 32'(tx_busy), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] d [10];
    int unsigned c;
    int unsigned f;
    int unsigned b;
    logic        exp_tx;

    #12;
    chk("rst.tx",   32'(tx),       32'd1);
    chk("rst.rdy",  32'(tx_rdy),   32'd1);
    chk("rst.ovf",  32'(overflow), 32'd0);
    chk("rst.lvl",  32'(level),    32'd0);
    chk("rst.busy", 32'(tx_busy),  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_frame("8n1_55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 19'd4, 4, 16'h02AA, 10);
    run_frame("7e2_41", 8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 19'd3, 3, 16'h0682, 11);
    run_frame("5o2_ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 19'd3, 3, 16'h01BE, 9);
    run_frame("k0_6n1", 8'h3C, 2'b01, 1'b0, 1'b0, 1'b0, 19'd0, 2, 16'h00F8, 8);
    run_frame("k1_8n1", 8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 19'd1, 2, 16'h021E, 10);

    // Ten writes on consecutive edges, 8N1 at k=2.
    for (int i = 0; i < 10; i++) d[i] = 8'(i * 37 + 5);
    data_bits = 2'b11; pen = 1'b0; ohel = 1'b0; stop2 = 1'b0; k = 19'd2;
    wr_data = d[0]; wr_en = 1'b1;
    for (int unsigned j = 0; j <= 182; j++) begin
      @(posedge clk); #1;
      if (j < 9) wr_data = d[j + 1];
      else       wr_en = 1'b0;
      if (j == 8) begin
        chk("ovf.lvl8", 32'(level),  32'd8);
        chk("ovf.rdy0", 32'(tx_rdy), 32'd0);
        chk("ovf.pre",  32'(overflow), 32'd0);
      end
      if (j == 9) begin
        chk("ovf.pulse", 32'(overflow), 32'd1);
        chk("ovf.lvl",   32'(level),    32'd8);
      end
      if (j == 10) chk("ovf.clear", 32'(overflow), 32'd0);
      if (j >= 1 && j <= 180) chk("b2b.busy", 32'(tx_busy), 32'd1);
      if (j == 181) chk("b2b.done", 32'(tx_busy), 32'd0);
      if (j == 182) chk("b2b.lvl0", 32'(level), 32'd0);
      if (j >= 2 && j <= 181) begin
        c = j - 2;
        f = c / 20;
        b = (c % 20) / 2;
        if (b == 0)      exp_tx = 1'b0;
        else if (b == 9) exp_tx = 1'b1;
        else             exp_tx = d[f][b - 1];
        chk("b2b.tx", 32'(tx), 32'(exp_tx));
      end
    end

    // Abort mid-DATA with three entries still queued.
    data_bits = 2'b11; pen = 1'b0; ohel = 1'b0; stop2 = 1'b0; k = 19'd4;
    wr_data = 8'h00; wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) wr_en = 1'b0;
    end
    repeat (7) @(posedge clk);
    #1;
    chk("abort.lvl3", 32'(level),   32'd3);
    chk("abort.busy", 32'(tx_busy), 32'd1);
    chk("abort.tx0",  32'(tx),      32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort.tx",   32'(tx),      32'd1);
    chk("abort.lvl",  32'(level),   32'd0);
    chk("abort.bsy",  32'(tx_busy), 32'd0);
    chk("abort.rdy",  32'(tx_rdy),  32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("quiet.tx",   32'(tx),      32'd1);
      chk("quiet.busy", 32'(tx_busy), 32'd0);
    end
    run_frame("resume", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 19'd4, 4, 16'h02AA, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised next-generation UART transmit engine with a FIFO in front of the serialiser.
- Host pushes bytes back-to-back without waiting for each frame to finish.
- Frame format selected at run time: 5–8 data bits, parity none/even/odd, 1 or 2 stop bits, programmable bit-time divisor.
- Sits between the processor output port and the TX pin; pairs with the existing receive engine in the full UART.

Parameters:
- DATA_W, 8, maximum data bits per frame and write-data width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DIV_W, 19, bit-time divisor width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  DATA_W  byte to send; LSB transmitted first
- data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- pen  in  1  parity enable
- ohel  in  1  parity sense: 1=odd, 0=even
- stop2  in  1  1=two stop bits
- k  in  DIV_W  clocks per bit
- tx_rdy  out  1  FIFO not full
- overflow  out  1  one-cycle pulse when a write is dropped
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- tx_busy  out  1  frame in progress
- tx  out  1  serial line; idle high

Behaviour:
- Reset (rst low, asynchronous): tx=1, tx_rdy=1, overflow=0, level=0, tx_busy=0, FSM=IDLE, counters cleared. Asserting reset mid-frame aborts the frame; tx returns high immediately.
- FIFO write:
  - wr_en accepted when level<DEPTH.
  - When full, the write is dropped, FIFO contents are unchanged, and overflow pulses 1 cycle.
  - A write and a pop in the same cycle are both honoured; level is unchanged.
  - When full, a simultaneous pop does not make room for that write; the write is dropped.
- Pointers wrap modulo DEPTH. level is registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when level>0, pop the head entry and latch data, data_bits, pen, ohel, stop2 and k into a frame register. Go to START; tx_busy=1 from the same edge.
- Configuration inputs may change freely; they affect only the next frame loaded.
- START: tx=0 for one bit time.
- DATA: shift out n bits, n=5..8 from data_bits, LSB first, one bit time each. Bits above n are ignored.
- PARITY (entered only if pen=1): one bit time. The parity bit is XOR of the n data bits, inverted when ohel=1.
- STOP: tx=1 for 1 bit time, or 2 if stop2=1. At the end of the last stop bit:
  - if level>0, go directly to START with the next entry (no idle gap);
  - otherwise go to IDLE and clear tx_busy.
- Bit time: a counter runs 0..k_eff-1, where k_eff = max(k,2). A bit-time-up strobe fires at count k_eff-1, then the counter reloads 0. The counter is held at 0 in IDLE.
- tx is a registered output.
- Latency: wr_en sampled at edge N into an empty, idle block gives a pop at edge N+1; tx falls at edge N+2. A frame lasts (1+n+pen+1+stop2)·k_eff clocks.
- Width rule: data_bits values that select more than DATA_W bits saturate to DATA_W.

Optional Feature:
- Macro TX_BREAK_EN.
- Defined: adds input send_break. While send_break=1 in IDLE, or at a frame boundary, the FSM enters BREAK and drives tx=0. The FIFO is not popped.
- On send_break falling, the FSM holds tx=1 for one full bit time (mark-after-break), then resumes at IDLE.
- A break request arriving mid-frame waits until the current frame's stop bits complete.
- Undefined: no port, no BREAK state; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK);
  - data_bits encoding constants DB5..DB8;
  - localparam MIN_K=2.
- One sub-module, sync_fifo (DATA_W, DEPTH), with ports wr_en, wr_data, rd_en, rd_data, level, full, empty. It is reused later by the receive path.

Test Plan:
- k=4, 8N1, write 0x55 into idle block -> tx low at edge N+2; bits 1,0,1,0,1,0,1,0; stop high; total 40 clocks; tx_busy low afterwards.
- k=3, 7 bits, pen=1, ohel=0, stop2=1, write 0x41 -> start, 1000001, parity 0, two stop bits; 33 clocks.
- Same with ohel=1 and 5 data bits, write 0xFF -> 5 ones, parity 0 (odd); bit 5..7 not sent.
- DEPTH=8, k=2, write 10 bytes in consecutive cycles -> 1 accepted and popped immediately plus 8 queued; 10th write: overflow pulse, level stays 8; the 9 frames sent back-to-back with no idle cycles between stop and start.
- Assert rst low mid-DATA with 3 entries queued -> tx=1, level=0, tx_busy=0 immediately; no output after release until a new write.
- k=0 and k=1 programmed -> bit time 2 clocks each.
